// File: rtl/seg_digit_scheduler.sv
// seg_digit_scheduler
// Shows a captured byte on one seven-segment display as two hex digits:
// the high nibble, a blank gap, the low nibble (with the decimal point lit),
// and a second blank gap. An internal prescaler makes a clock-enable tick,
// so the whole block runs on clk alone.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high reset
//   start  in   request to display value (ignored while busy)
//   value  in   byte captured when start is accepted
//   busy   out  high while a display sequence is in progress
//   seg    out  segments {g,f,e,d,c,b,a}, active-high
//   dp     out  decimal point, lit during the low-nibble digit
//   done   out  one-cycle pulse on the first idle cycle after a sequence
//
// state | meaning
// ------+-------------------------------------------
// IDLE  | display blank, waiting for start
// HI    | showing high nibble for SHOW_TICKS ticks
// GAP1  | blank for GAP_TICKS ticks
// LO    | showing low nibble with dp for SHOW_TICKS ticks
// GAP2  | blank for GAP_TICKS ticks, then back to IDLE

module seg_digit_scheduler #(
  parameter int TICK_DIV   = 4,
  parameter int SHOW_TICKS = 8,
  parameter int GAP_TICKS  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] value,
  output logic       busy,
  output logic [6:0] seg,
  output logic       dp,
  output logic       done
);

  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_MAX = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int CW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam bit HAS_GAP = (GAP_TICKS > 0);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(HAS_GAP ? GAP_TICKS - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_GAP1 = 3'd2,
    S_LO   = 3'd3,
    S_GAP2 = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      latch_q, latch_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   phase_q, phase_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            tick;
  logic [CW-1:0]   phase_last;
  state_t          state_after;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    presc_d = presc_q;
    phase_d = phase_q;
    done_d  = 1'b0;

    tick       = (presc_q == PRESC_LAST);
    phase_last = (state_q == S_GAP1 || state_q == S_GAP2) ? GAP_LAST : SHOW_LAST;

    case (state_q)
      S_HI:    state_after = HAS_GAP ? S_GAP1 : S_LO;
      S_GAP1:  state_after = S_LO;
      S_LO:    state_after = HAS_GAP ? S_GAP2 : S_IDLE;
      default: state_after = S_IDLE;
    endcase

    if (state_q == S_IDLE) begin
      presc_d = '0;
      phase_d = '0;
      if (start) begin
        latch_d = value;
        state_d = S_HI;
      end
    end else begin
      // prescaler free-runs across phase boundaries
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (phase_q == phase_last) begin
          phase_d = '0;
          state_d = state_after;
          done_d  = (state_after == S_IDLE);
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end

    // outputs are registered, so decode from the state being entered
    seg_d  = 7'h00;
    dp_d   = 1'b0;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_HI:    seg_d = hex7(latch_d[7:4]);
      S_LO: begin
        seg_d = hex7(latch_d[3:0]);
        dp_d  = 1'b1;
      end
      default: seg_d = 7'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      latch_q <= 8'h00;
      presc_q <= '0;
      phase_q <= '0;
      seg_q   <= 7'h00;
      dp_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      latch_q <= latch_d;
      presc_q <= presc_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seg_digit_scheduler.sv
// Directed bench for seg_digit_scheduler: default-parameter instance plus a
// fast instance (TICK_DIV=1, GAP_TICKS=0). Expected outputs per cycle are
// packed as {busy, done, dp, seg}.

module tb_seg_digit_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, start_f;
  logic [7:0] value, value_f;
  logic       busy, dp, done;
  logic [6:0] seg;
  logic       busy_f, dp_f, done_f;
  logic [6:0] seg_f;

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [7:0] vals [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

  always #5 clk = ~clk;

  seg_digit_scheduler u_dut (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy), .seg(seg), .dp(dp), .done(done)
  );

  seg_digit_scheduler #(.TICK_DIV(1), .SHOW_TICKS(8), .GAP_TICKS(0)) u_fast (
    .clk(clk), .reset(reset), .start(start_f), .value(value_f),
    .busy(busy_f), .seg(seg_f), .dp(dp_f), .done(done_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // cycle c counts from 1 = first cycle after the accepting edge
  function automatic logic [9:0] exp_def(input int c, input logic [7:0] v);
    if (c >= 1 && c <= 32)       return {1'b1, 1'b0, 1'b0, hex_tab[v[7:4]]};
    else if (c >= 33 && c <= 40) return {1'b1, 1'b0, 1'b0, 7'h00};
    else if (c >= 41 && c <= 72) return {1'b1, 1'b0, 1'b1, hex_tab[v[3:0]]};
    else if (c >= 73 && c <= 80) return {1'b1, 1'b0, 1'b0, 7'h00};
    else if (c == 81)            return {1'b0, 1'b1, 1'b0, 7'h00};
    else                         return 10'h000;
  endfunction

  function automatic logic [31:0] obs_d();
    return 32'({busy, done, dp, seg});
  endfunction

  function automatic logic [31:0] obs_f();
    return 32'({busy_f, done_f, dp_f, seg_f});
  endfunction

  task automatic run_seq(input logic [7:0] v, input int ign_at, input string tag);
    start = 1'b1;
    value = v;
    @(posedge clk); #1;
    start = 1'b0;
    value = ~v;
    for (int c = 1; c <= 82; c++) begin
      chk($sformatf("%s c%0d", tag, c), obs_d(), 32'(exp_def(c, v)));
      if (c == ign_at) begin
        start = 1'b1;
        value = 8'hFF;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    start_f = 1'b0;
    value   = 8'h00;
    value_f = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dut", obs_d(), 32'h0);
    chk("rst_fast", obs_f(), 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_dut", obs_d(), 32'h0);
    chk("idle_fast", obs_f(), 32'h0);

    // basic sequence, then one with an ignored start at cycle 20
    run_seq(8'h3A, 0, "seq3A");
    run_seq(8'h3A, 20, "ign");

    // start held high: back-to-back sequences every 81 cycles
    start = 1'b1;
    value = 8'h00;
    @(posedge clk); #1;
    for (int c = 1; c <= 163; c++) begin
      chk($sformatf("hold c%0d", c), obs_d(),
          (c <= 162) ? 32'(exp_def(((c - 1) % 81) + 1, 8'h00)) : 32'h0);
      if (c == 162) start = 1'b0;
      @(posedge clk); #1;
    end

    // reset asserted mid-LO
    start = 1'b1;
    value = 8'h3A;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      chk($sformatf("abort c%0d", c), obs_d(), 32'(exp_def(c, 8'h3A)));
      if (c < 50) begin
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b1;
    #1 chk("abort_async", obs_d(), 32'h0);
    @(posedge clk); #1;
    chk("abort_held", obs_d(), 32'h0);
    reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst c%0d", c), obs_d(), 32'h0);
    end

    // all sixteen hex digits
    for (int i = 0; i < 8; i++) run_seq(vals[i], 0, $sformatf("v%02h", vals[i]));

    // fast instance: TICK_DIV=1, no gaps
    start_f = 1'b1;
    value_f = 8'h5C;
    @(posedge clk); #1;
    start_f = 1'b0;
    value_f = 8'hA5;
    for (int c = 1; c <= 18; c++) begin
      logic [9:0] e;
      if (c <= 8)       e = {1'b1, 1'b0, 1'b0, 7'h6D};
      else if (c <= 16) e = {1'b1, 1'b0, 1'b1, 7'h39};
      else if (c == 17) e = {1'b0, 1'b1, 1'b0, 7'h00};
      else              e = 10'h000;
      chk($sformatf("fast c%0d", c), obs_f(), 32'(e));
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
